// File: rtl/tug_of_war_input_unit_if.sv
// Bus interface for the tug-of-war input unit.
// Groups the player button, difficulty switches and every observable output
// so the unit and its environment connect through one port.
//   key_n   : human button, active-low, asynchronous to clk
//   sw      : computer difficulty threshold (9 bits, static during play)
//   lfsr_q  : current pseudo-random state (9 bits)
//   sum     : sw + lfsr_q, full 10-bit result
//   cpu_raw : computer "press" level (carry out of the add)
//   left    : single-cycle computer press pulse
//   right   : single-cycle human press pulse
// The master modport drives key_n/sw and observes the rest; the slave
// modport is the unit itself.
interface tug_of_war_input_unit_if;
  logic       key_n;
  logic [8:0] sw;
  logic [8:0] lfsr_q;
  logic [9:0] sum;
  logic       cpu_raw;
  logic       left;
  logic       right;

  modport master (
    output key_n, sw,
    input  lfsr_q, sum, cpu_raw, left, right
  );

  modport slave (
    input  key_n, sw,
    output lfsr_q, sum, cpu_raw, left, right
  );
endinterface

// File: rtl/tug_of_war_input_unit.sv
// Tug-of-war input unit.
// Turns the human button and a pseudo-random computer "opponent" into
// single-cycle press pulses.  A 9-bit XNOR Fibonacci LFSR is added to the
// difficulty switches; the carry out of that add is the computer's press
// level.  Both press levels pass through identical two-stage rising-edge
// detectors.
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : asynchronous, active-high reset of every register
//   bus : tug_of_war_input_unit_if.slave (key_n, sw in; lfsr_q, sum,
//         cpu_raw, left, right out)

// Rising-edge detector: s1 doubles as the synchroniser stage for the
// asynchronous button, s2 holds the previous sample.
module press_detector (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= level;
      s2 <= s1;
    end
  end

  assign pulse = s1 & ~s2;
endmodule

module tug_of_war_input_unit (
  input  logic                     clk,
  input  logic                     rst,
  tug_of_war_input_unit_if.slave   bus
);
  logic [8:0] lfsr;
  logic       fb;
  logic [9:0] sum_full;
  logic       human_level;
  logic       cpu_level;
  logic       left_pulse;
  logic       right_pulse;

  // XNOR feedback makes all-ones the lock-up state, so reset to zero is a
  // legal member of the 511-state cycle.
  assign fb = ~(lfsr[8] ^ lfsr[4]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 9'h000;
    end else begin
      lfsr <= {lfsr[7:0], fb};
    end
  end

  // Carry out of the 9+9 add is the computer press level: larger sw makes
  // the computer press more often; sw = 0 can never carry.
  assign sum_full  = {1'b0, bus.sw} + {1'b0, lfsr};
  assign cpu_level = sum_full[9];

  assign human_level = ~bus.key_n;

  press_detector u_human_det (
    .clk   (clk),
    .rst   (rst),
    .level (human_level),
    .pulse (right_pulse)
  );

  press_detector u_cpu_det (
    .clk   (clk),
    .rst   (rst),
    .level (cpu_level),
    .pulse (left_pulse)
  );

  assign bus.lfsr_q  = lfsr;
  assign bus.sum     = sum_full;
  assign bus.cpu_raw = cpu_level;
  assign bus.left    = left_pulse;
  assign bus.right   = right_pulse;
endmodule

// File: tb/tb_tug_of_war_input_unit.sv
// Self-checking bench for tug_of_war_input_unit.
// A reference model built from the behavioural rules (shift-and-XNOR
// arithmetic on an integer, "press = sampled now and not sampled before")
// predicts every output after each rising edge.
module tb_tug_of_war_input_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  tug_of_war_input_unit_if bus ();

  tug_of_war_input_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mLfsr = 0;
  bit prevH = 1'b0;
  bit prevC = 1'b0;
  bit mLeft = 1'b0;
  bit mRight = 1'b0;

  typedef struct {
    logic [8:0] sw;
    logic       keyN;
    logic [8:0] expLfsr;
    logic [9:0] expSum;
    logic       expCpu;
    logic       expLeft;
    logic       expRight;
  } vec_t;

  vec_t vecs[12];

  function automatic int refNext(int s);
    int tap9;
    int tap5;
    tap9 = (s / 256) % 2;
    tap5 = (s / 16) % 2;
    return ((s * 2) % 512) + ((tap9 == tap5) ? 1 : 0);
  endfunction

  task automatic checkVal(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mLfsr  = 0;
    prevH  = 1'b0;
    prevC  = 1'b0;
    mLeft  = 1'b0;
    mRight = 1'b0;
  endtask

  // Called right at a rising edge, before inputs change.
  task automatic modelEdge();
    bit hIn;
    bit cIn;
    hIn    = !bus.key_n;
    cIn    = (int'(bus.sw) + mLfsr) >= 512;
    mRight = hIn && !prevH;
    mLeft  = cIn && !prevC;
    prevH  = hIn;
    prevC  = cIn;
    mLfsr  = refNext(mLfsr);
  endtask

  task automatic checkOutput(string tag);
    int expSum;
    expSum = int'(bus.sw) + mLfsr;
    checkVal({tag, " lfsr_q"}, int'(bus.lfsr_q), mLfsr);
    checkVal({tag, " sum"}, int'(bus.sum), expSum);
    checkVal({tag, " cpu_raw"}, int'(bus.cpu_raw), (expSum >= 512) ? 1 : 0);
    checkVal({tag, " left"}, int'(bus.left), int'(mLeft));
    checkVal({tag, " right"}, int'(bus.right), int'(mRight));
  endtask

  task automatic stepCycle(string tag);
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus();
    vecs[0]  = '{9'h000, 1'b1, 9'h001, 10'h001, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{9'h000, 1'b1, 9'h003, 10'h003, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{9'h000, 1'b1, 9'h007, 10'h007, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{9'h000, 1'b1, 9'h00F, 10'h00F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{9'h000, 1'b1, 9'h01F, 10'h01F, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{9'h000, 1'b1, 9'h03E, 10'h03E, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{9'h000, 1'b1, 9'h07C, 10'h07C, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{9'h000, 1'b1, 9'h0F8, 10'h0F8, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{9'h000, 1'b1, 9'h1F0, 10'h1F0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{9'h000, 1'b1, 9'h1E1, 10'h1E1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{9'h000, 1'b0, 9'h1C2, 10'h1C2, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{9'h000, 1'b0, 9'h184, 10'h184, 1'b0, 1'b0, 1'b0};
  endtask

  initial begin
    int seen[512];
    int bad;
    int pulses;
    int firstAt;

    bus.key_n = 1'b1;
    bus.sw    = 9'h000;
    #1;
    modelReset();
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors from reset with sw = 0
    applyStimulus();
    for (int i = 0; i < 12; i++) begin
      bus.sw    = vecs[i].sw;
      bus.key_n = vecs[i].keyN;
      stepCycle("table");
      checkVal($sformatf("vec%0d lfsr_q", i), int'(bus.lfsr_q), int'(vecs[i].expLfsr));
      checkVal($sformatf("vec%0d sum", i), int'(bus.sum), int'(vecs[i].expSum));
      checkVal($sformatf("vec%0d cpu_raw", i), int'(bus.cpu_raw), int'(vecs[i].expCpu));
      checkVal($sformatf("vec%0d left", i), int'(bus.left), int'(vecs[i].expLeft));
      checkVal($sformatf("vec%0d right", i), int'(bus.right), int'(vecs[i].expRight));
    end
    bus.key_n = 1'b1;

    // Adder boundary: sw = 0x1FF with lfsr 0 then 1
    bus.sw = 9'h1FF;
    applyReset();
    checkVal("max sw at zero sum", int'(bus.sum), 'h1FF);
    checkVal("max sw at zero cpu_raw", int'(bus.cpu_raw), 0);
    stepCycle("max sw");
    checkVal("max sw at one sum", int'(bus.sum), 'h200);
    checkVal("max sw at one cpu_raw", int'(bus.cpu_raw), 1);
    // Human press lands on the same edge that samples cpu_raw rising
    bus.key_n = 1'b0;
    stepCycle("both");
    checkVal("both left", int'(bus.left), 1);
    checkVal("both right", int'(bus.right), 1);
    bus.key_n = 1'b1;

    // Held button gives a single pulse, twice
    bus.sw = 9'h000;
    applyReset();
    for (int rep = 0; rep < 2; rep++) begin
      bus.key_n = 1'b0;
      pulses  = 0;
      firstAt = -1;
      for (int c = 0; c < 10; c++) begin
        stepCycle("hold");
        if (bus.right) begin
          pulses++;
          if (firstAt < 0) firstAt = c;
        end
      end
      checkVal($sformatf("hold%0d pulse count", rep), pulses, 1);
      checkVal($sformatf("hold%0d pulse cycle", rep), firstAt, 0);
      bus.key_n = 1'b1;
      stepCycle("release");
      stepCycle("release");
    end

    // Asynchronous reset while right is high
    bus.key_n = 1'b0;
    stepCycle("pre async");
    checkVal("pre async right", int'(bus.right), 1);
    #2;
    rst = 1'b1;
    #1;
    checkVal("async right", int'(bus.right), 0);
    checkVal("async left", int'(bus.left), 0);
    checkVal("async lfsr_q", int'(bus.lfsr_q), 0);
    modelReset();
    // Button held through release: one pulse after the first edge
    @(negedge clk);
    rst = 1'b0;
    stepCycle("held release");
    checkVal("held release right1", int'(bus.right), 1);
    stepCycle("held release");
    checkVal("held release right2", int'(bus.right), 0);
    bus.key_n = 1'b1;

    // Full period walk
    bus.sw = 9'h000;
    applyReset();
    for (int v = 0; v < 512; v++) seen[v] = 0;
    seen[0] = 1;
    for (int c = 1; c <= 511; c++) begin
      stepCycle("period");
      if (c < 511) seen[int'(bus.lfsr_q)]++;
    end
    checkVal("period returns to zero", int'(bus.lfsr_q), 0);
    checkVal("period lock-up visits", seen[511], 0);
    bad = 0;
    for (int v = 0; v < 511; v++) if (seen[v] != 1) bad++;
    checkVal("period values not seen once", bad, 0);

    // Randomised play against the model
    for (int round = 0; round < 4; round++) begin
      bus.sw = 9'($urandom_range(0, 511));
      applyReset();
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 3) == 0) bus.key_n = ~bus.key_n;
        stepCycle("random");
        if ($urandom_range(0, 59) == 0) applyReset();
      end
      bus.key_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tug_of_war_input_unit.md
TUG_OF_WAR_INPUT_UNIT -- requirements
Module: tug_of_war_input_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset of every register in the block.
REQ-004 key_n  input  1  human player button, active-low (0 = pressed), asynchronous to Clock.
REQ-005 sw  input  9  computer difficulty threshold, unsigned, static during play.
REQ-006 lfsr_q  output  9  current pseudo-random state.
REQ-007 sum  output  10  unsigned sum sw + lfsr_q, 10-bit, no truncation.
REQ-008 cpu_raw  output  1  computer "press" level, equal to sum[9].
REQ-009 Left  output  1  single-cycle computer press pulse.
REQ-010 Right  output  1  single-cycle human press pulse.

Function
REQ-011 LFSR: 9-bit Fibonacci register; each Clock edge, lfsr_q <= {lfsr_q[7:0], fb}.
REQ-012 LFSR feedback: fb = NOT(lfsr_q[8] XOR lfsr_q[4]), i.e. XNOR of taps 9 and 5.
REQ-013 LFSR period: 511 states; all-ones (0x1FF) is the lock-up state and is unreachable from reset.
REQ-014 LFSR advances every cycle unconditionally; no enable.
REQ-015 Adder: purely combinational 9+9-bit unsigned add; carry-in tied 0; sum[9] is the carry-out.
REQ-016 cpu_raw = sum[9]; asserted iff sw + lfsr_q >= 512; sw = 0 never asserts it.
REQ-017 Press detector: an identical edge-detector instance on each input, human input = NOT key_n, computer input = cpu_raw.
REQ-018 Detector: stage s1 <= input, stage s2 <= s1; output = s1 AND NOT s2.
REQ-019 Detector latency: input rising before edge k gives an output high from after edge k until edge k+1, exactly one cycle.
REQ-020 Held input: one pulse only; a new pulse requires the input to drop for at least one sampled cycle and rise again.
REQ-021 Input glitches not spanning a Clock edge SHALL produce no pulse.
REQ-022 Left and Right are independent; both may pulse in the same cycle; no arbitration inside this block.
REQ-023 The computer detector input depends on lfsr_q of the current cycle, so Left may pulse in consecutive-but-one cycles when cpu_raw toggles.

Reset
REQ-024 While Reset = 1: lfsr_q = 0x000, all detector stages = 0, Left = 0, Right = 0, regardless of Clock.
REQ-025 sum and cpu_raw SHALL follow sw + 0x000 combinationally during reset.
REQ-026 Reset asserted mid-operation clears all state immediately; pulses in progress are cancelled.
REQ-027 After Reset release, the first edge loads lfsr_q = 0x001; no pulse SHALL occur on the first post-reset cycle unless the input is high at that edge.
REQ-028 The human input held pressed through reset release produces exactly one Right pulse, one cycle after the first post-release edge.

Verification
REQ-029 Reset, release, sw = 0 -> lfsr_q sequence 000,001,003,007,00F,01F,03E,07C,0F8,1F0,1E1; cpu_raw stays 0; Left never pulses.
REQ-030 sw = 0x1FF with lfsr_q = 0x001 -> sum = 0x200, cpu_raw = 1; with lfsr_q = 0x000 -> sum = 0x1FF, cpu_raw = 0.
REQ-031 key_n driven low and held 10 cycles -> Right high for exactly one cycle, one cycle after the sampling edge; release and press again -> second single pulse.
REQ-032 Run 511 cycles from reset -> lfsr_q returns to 0x000, never equals 0x1FF, and every other 9-bit value appears exactly once.
REQ-033 Reset asserted between clock edges while Right is high -> Right, Left and lfsr_q go to 0 without waiting for an edge.
REQ-034 key_n low and cpu_raw rising at the same edge -> Left and Right pulse in the same cycle.
